// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states and instruction/address geometry.
package cpu_pkg;

  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_STEP = 4;

  localparam logic [INSTR_W-1:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, drives the instruction memory address and holds one
// fetched instruction for decode behind a valid/ready handshake. Supports redirect and halt.
module instr_fetch #(
  parameter int unsigned             ADDR_W    = cpu_pkg::ADDR_W,
  parameter int unsigned             INSTR_W   = cpu_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0]       RESET_PC  = '0,
  parameter logic [INSTR_W-1:0]      HALT_WORD = cpu_pkg::HALT_WORD
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic               halted
);

  import cpu_pkg::*;

  fetch_state_t       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               out_valid_q, out_valid_d;
  logic [INSTR_W-1:0] out_instr_q, out_instr_d;
  logic [ADDR_W-1:0]  out_pc_q, out_pc_d;

  logic transfer;
  logic slot_free;

  // Low address bits of a redirect target are dropped; fetch is always word aligned.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  assign transfer  = out_valid_q && out_ready;
  assign slot_free = !out_valid_q || out_ready;

  // Next-state, PC mux (redirect > advance > hold) and output-slot update.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;

    if (redirect_valid) begin
      // Flush wins over any capture; a same-edge transfer has already been taken by decode.
      pc_d        = {redirect_pc[ADDR_W-1:2], 2'b00};
      out_valid_d = 1'b0;
      state_d     = fetch_en ? RUN : IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (transfer) out_valid_d = 1'b0;
          if (fetch_en) state_d = RUN;
        end
        RUN: begin
          if (!fetch_en) begin
            state_d = IDLE;
            if (transfer) out_valid_d = 1'b0;
          end else if (slot_free) begin
            out_valid_d = 1'b1;
            out_instr_d = imem_data;
            out_pc_d    = pc_q;
            if (imem_data == HALT_WORD) begin
              state_d = HALT;
            end else begin
              pc_d = pc_q + ADDR_W'(PC_STEP);
            end
          end
        end
        HALT: begin
          if (transfer) out_valid_d = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, PC and output register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_pc_q    <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
    end
  end

  assign imem_addr = pc_q;
  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_pc    = out_pc_q;
  assign halted    = (state_q == HALT);

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit: the initiator side of the instruction memory's combinational read port. It holds the program counter, drives the 10-bit byte address into `Instruction_Mem`, and captures the returned 32-bit word into a one-entry output register. That register feeds decode through a valid/ready handshake. It also supports branch redirect and halt detection.

## Interface
- `ADDR_W`, default 10: byte-address width; matches the instruction memory address port.
- `INSTR_W`, default 32: instruction width.
- `RESET_PC`, default 0: PC value after reset; word aligned.
- `HALT_WORD`, default 32'hFFFF_FFFF: instruction encoding that stops fetch.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `fetch_en` input 1: run request from control.
- `imem_addr` output ADDR_W: address to the instruction memory; equals the PC register combinationally.
- `imem_data` input INSTR_W: word returned by the memory in the same cycle.
- `redirect_valid` input 1: branch/jump taken, single-cycle pulse.
- `redirect_pc` input ADDR_W: target address; bits [1:0] ignored and forced to 0.
- `out_valid` output 1: `out_instr`/`out_pc` hold a fetched instruction.
- `out_ready` input 1: decode accepts the current instruction.
- `out_instr` output INSTR_W: fetched instruction.
- `out_pc` output ADDR_W: address the instruction was fetched from.
- `halted` output 1: high while in HALT.

## Operation
- States:
  - IDLE: reset state; no capture.
  - RUN: fetching.
  - HALT: stopped after `HALT_WORD`.
- Transfer: occurs on a rising edge with `out_valid && out_ready`.
- Slot free: `!out_valid || out_ready`.
- IDLE:
  - `fetch_en=1` → RUN next edge.
  - PC unchanged.
- RUN, `fetch_en=1`, slot free, no redirect, on the edge:
  - `out_instr<=imem_data`, `out_pc<=pc`, `out_valid<=1`.
  - `pc<=pc+4`, modulo 2^ADDR_W: 1020 wraps to 0.
- RUN, slot not free: PC, `out_*` and state hold (stall).
- RUN, `fetch_en=0`: no capture; state → IDLE. A pending `out_valid` stays until transferred.
- HALT_WORD captured:
  - The word is still presented with `out_valid=1`.
  - PC is not incremented; state → HALT.
- HALT:
  - No captures; `halted=1`.
  - Leaves only on redirect (→ RUN) or reset.
- Redirect (`redirect_valid=1`), highest priority, in any state:
  - `pc<={redirect_pc[ADDR_W-1:2],2'b00}`.
  - `out_valid<=0`, flushing the slot; no capture this edge.
  - State: RUN if `fetch_en=1`, else IDLE.
  - A transfer on the same edge still counts as accepted by decode.
- Reset values: `pc=RESET_PC`, so `imem_addr=RESET_PC`. Also `out_valid=0`, `out_instr=0`, `out_pc=0`, `halted=0`, state IDLE.

## Timing
- `imem_addr` is combinational from the PC register only. There is no path from `imem_data`, `out_ready` or `redirect_*` to `imem_addr`.
- All `out_*` and `halted` are registered.
- Latency:
  - `fetch_en` high before edge E0 → RUN after E0.
  - First `out_valid` after E1, carrying address `RESET_PC`.
- Throughput: one instruction per cycle with `out_ready` held high.
- Redirect latency:
  - Pulse before edge E → `imem_addr=target` after E.
  - Target instruction valid after E+1.
  - Redirect penalty is one bubble cycle.
- Stall: the address and output register are held bit-exact for any number of cycles.
- Reset asserted mid-operation: outputs go to reset values immediately, without waiting for a clock edge. Fetch restarts from `RESET_PC` after deassertion and `fetch_en`.

## Structure
- Shared package `cpu_pkg` holds:
  - `fetch_state_t` enum {IDLE, RUN, HALT}.
  - `ADDR_W`, `INSTR_W`.
  - `PC_STEP=4`.
  - `HALT_WORD`.
- Single module, no sub-modules.
- The PC next-value mux uses priority: reset, redirect, advance, hold. It is a single always block, with no separate pc_gen.
- The bench instantiates `instr_fetch` together with `Instruction_Mem` as the memory model.

## Test plan
- Reset, `fetch_en=1`, `out_ready=1`:
  - Instructions from addresses 0, 4, 8 appear on consecutive cycles with `out_pc` = 0, 4, 8.
  - The first one appears two edges after `fetch_en`.
- Stall: `out_ready=0` for 3 cycles while `out_pc=4`:
  - `imem_addr=8`, `out_instr` and `out_pc=4` are held.
  - After `out_ready=1`, `out_pc=8` on the next cycle.
- Redirect to 10'd102 while `out_pc=8` is valid and `out_ready=1`:
  - Next cycle: `out_valid=0`, `imem_addr=100`.
  - Following cycle: `out_pc=100`.
- Wrap: redirect to 1020, run:
  - `out_pc` sequence is 1020, then 0.
- Halt: place `HALT_WORD` at address 12:
  - `out_pc=12` is presented, then `halted=1` and no further `out_valid`.
  - Redirect to 0 resumes fetch with `out_pc=0`.
- Async reset asserted mid-run between edges:
  - `out_valid=0` and `imem_addr=0` immediately.
  - After release, no output until `fetch_en`.
